// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, deframes 11-bit
// frames and decodes Set-2 E0/F0 prefixes into make-code pulses for the game stage.
module ps2_key_decoder #(
  parameter int FILTER_LEN    = 8,
  parameter int TIMEOUT       = 50000,
  parameter bit IGNORE_REPEAT = 1'b1
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_in,
  output logic       key_en,
  output logic       key_ext,
  output logic       key_held,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk;
  logic                  sample_evt;
  logic                  sample_bit;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift_reg;
  logic                  parity_bit;
  logic [TW-1:0]         tmo_cnt;
  logic                  ext_f;
  logic                  brk_f;
  logic                  same_key;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_sr   <= '1;
      filt_clk  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt_sr   <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
      if (&filt_sr)
        filt_clk <= 1'b1;
      else if (~|filt_sr)
        filt_clk <= 1'b0;
    end
  end

  // The event is the single cycle where the filter is all-low but the level is still high.
  assign sample_evt = filt_clk & ~|filt_sr;
  assign sample_bit = data_sync[1];
  assign same_key   = (shift_reg == key_in) && (ext_f == key_ext);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
      ext_f      <= 1'b0;
      brk_f      <= 1'b0;
      key_in     <= 8'h00;
      key_en     <= 1'b0;
      key_ext    <= 1'b0;
      key_held   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_en    <= 1'b0;
      frame_err <= 1'b0;
      // tmo_cnt holds the number of cycles elapsed since the last sample event.
      if (sample_evt)
        tmo_cnt <= TW'(1);
      else if (state == IDLE)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;

      if (state != IDLE && !sample_evt && tmo_cnt == TW'(TIMEOUT - 1)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        ext_f     <= 1'b0;
        brk_f     <= 1'b0;
      end else if (sample_evt) begin
        case (state)
          IDLE: begin
            if (!sample_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {sample_bit, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            parity_bit <= sample_bit;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (sample_bit && ^{shift_reg, parity_bit}) begin
              if (shift_reg == 8'hE0) begin
                ext_f <= 1'b1;
              end else if (shift_reg == 8'hF0) begin
                brk_f <= 1'b1;
              end else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
                if (brk_f) begin
                  if (same_key)
                    key_held <= 1'b0;
                end else if (!(IGNORE_REPEAT && key_held && same_key)) begin
                  key_in   <= shift_reg;
                  key_ext  <= ext_f;
                  key_held <= 1'b1;
                  key_en   <= 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
              ext_f     <= 1'b0;
              brk_f     <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: key events are queued as frames are sent and
// compared when key_en fires; error pulses are checked for count and cycle position.
module tb_ps2_key_decoder;

  localparam int FL = 8;
  localparam int TO = 300;

  typedef struct {
    logic [7:0] code;
    logic       ext;
  } key_t;

  logic       iCLK = 1'b0;
  logic       iRST_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_in;
  logic       key_en;
  logic       key_ext;
  logic       key_held;
  logic       frame_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   err_cyc = 0;
  int   err_count = 0;
  int   en_count = 0;
  int   exp_err = 0;
  int   exp_en = 0;
  logic prev_en = 1'b0;
  key_t exp_q[$];

  ps2_key_decoder #(
    .FILTER_LEN   (FL),
    .TIMEOUT      (TO),
    .IGNORE_REPEAT(1'b1)
  ) dut (
    .iCLK     (iCLK),
    .iRST_n   (iRST_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_in   (key_in),
    .key_en   (key_en),
    .key_ext  (key_ext),
    .key_held (key_held),
    .frame_err(frame_err)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every key_en must match the oldest queued key event.
  always @(negedge iCLK) begin
    if (iRST_n) begin
      if (frame_err) begin
        err_count++;
        err_cyc = cyc;
      end
      if (key_en) begin
        key_t e;
        en_count++;
        checkOutput("key_en_single_cycle", {31'd0, prev_en}, 32'd0);
        checkOutput("key_en_expected", exp_q.size(), (exp_q.size() == 0) ? 32'd1 : exp_q.size());
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("key_in_on_en", {24'd0, key_in}, {24'd0, e.code});
          checkOutput("key_ext_on_en", {31'd0, key_ext}, {31'd0, e.ext});
        end
      end
    end
    prev_en = key_en;
  end

  task automatic send_bit(input logic v, input bit glitch);
    ps2_data = v;
    repeat (10) @(negedge iCLK);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (FL - 1) @(negedge iCLK);
      ps2_clk = 1'b1;
      repeat (12) @(negedge iCLK);
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (20) @(negedge iCLK);
    ps2_clk = 1'b1;
    repeat (10) @(negedge iCLK);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++)
      send_bit(frame[i], glitch);
    ps2_data = 1'b1;
    repeat (50) @(negedge iCLK);
  endtask

  task automatic push_key(input logic [7:0] code, input logic ext);
    key_t e;
    e.code = code;
    e.ext  = ext;
    exp_q.push_back(e);
    exp_en++;
  endtask

  initial begin
    int saved_fall;
    $display("[TB] start");
    repeat (3) @(negedge iCLK);
    checkOutput("rst_key_in", {24'd0, key_in}, 32'h00);
    checkOutput("rst_key_en", {31'd0, key_en}, 32'd0);
    checkOutput("rst_key_ext", {31'd0, key_ext}, 32'd0);
    checkOutput("rst_key_held", {31'd0, key_held}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
    iRST_n = 1'b1;
    repeat (20) @(negedge iCLK);

    // Extended make E0 75.
    applyStimulus(8'hE0, 1'b0, 1'b0, 11);
    push_key(8'h75, 1'b1);
    applyStimulus(8'h75, 1'b0, 1'b0, 11);
    checkOutput("ext_make_count", en_count, exp_en);
    checkOutput("ext_make_held", {31'd0, key_held}, 32'd1);
    checkOutput("ext_make_no_err", err_count, exp_err);

    // Two typematic repeats, then the extended break, then a fresh make.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(8'hE0, 1'b0, 1'b0, 11);
      applyStimulus(8'h75, 1'b0, 1'b0, 11);
    end
    checkOutput("repeat_suppressed", en_count, exp_en);
    applyStimulus(8'hE0, 1'b0, 1'b0, 11);
    applyStimulus(8'hF0, 1'b0, 1'b0, 11);
    applyStimulus(8'h75, 1'b0, 1'b0, 11);
    checkOutput("break_held", {31'd0, key_held}, 32'd0);
    checkOutput("break_no_en", en_count, exp_en);
    applyStimulus(8'hE0, 1'b0, 1'b0, 11);
    push_key(8'h75, 1'b1);
    applyStimulus(8'h75, 1'b0, 1'b0, 11);
    checkOutput("remake_count", en_count, exp_en);

    // Parity error.
    push_key(8'h6B, 1'b0);
    applyStimulus(8'h6B, 1'b0, 1'b0, 11);
    exp_err++;
    applyStimulus(8'h72, 1'b1, 1'b0, 11);
    checkOutput("parity_err_count", err_count, exp_err);
    checkOutput("parity_err_cycle", err_cyc, fall_cyc + 3 + FL);
    checkOutput("parity_key_in", {24'd0, key_in}, 32'h6B);
    checkOutput("parity_no_en", en_count, exp_en);
    push_key(8'h72, 1'b0);
    applyStimulus(8'h72, 1'b0, 1'b0, 11);
    checkOutput("after_parity_key_in", {24'd0, key_in}, 32'h72);

    // Truncated frame: start plus four data bits, then idle.
    exp_err++;
    applyStimulus(8'h55, 1'b0, 1'b0, 5);
    saved_fall = fall_cyc;
    repeat (TO + 50) @(negedge iCLK);
    checkOutput("timeout_err_count", err_count, exp_err);
    checkOutput("timeout_err_cycle", err_cyc, saved_fall + 2 + FL + TO);
    push_key(8'h74, 1'b0);
    applyStimulus(8'h74, 1'b0, 1'b0, 11);
    checkOutput("after_timeout_count", en_count, exp_en);

    // Short clock glitches inside a frame and while idle.
    push_key(8'h75, 1'b0);
    applyStimulus(8'h75, 1'b0, 1'b1, 11);
    checkOutput("glitch_frame_key_in", {24'd0, key_in}, 32'h75);
    checkOutput("glitch_frame_count", en_count, exp_en);
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      repeat (FL - 1) @(negedge iCLK);
      ps2_clk = 1'b1;
      repeat (20) @(negedge iCLK);
    end
    checkOutput("idle_glitch_no_en", en_count, exp_en);
    checkOutput("idle_glitch_no_err", err_count, exp_err);

    // Reset in the middle of a frame.
    for (int i = 0; i < 6; i++)
      send_bit((i == 0) ? 1'b0 : 1'b1, 1'b0);
    iRST_n = 1'b0;
    repeat (3) @(negedge iCLK);
    checkOutput("midrst_key_in", {24'd0, key_in}, 32'h00);
    checkOutput("midrst_key_en", {31'd0, key_en}, 32'd0);
    checkOutput("midrst_key_ext", {31'd0, key_ext}, 32'd0);
    checkOutput("midrst_key_held", {31'd0, key_held}, 32'd0);
    checkOutput("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    iRST_n = 1'b1;
    ps2_data = 1'b1;
    repeat (20) @(negedge iCLK);
    push_key(8'h72, 1'b0);
    applyStimulus(8'h72, 1'b0, 1'b0, 11);
    checkOutput("post_rst_count", en_count, exp_en);
    checkOutput("post_rst_key_in", {24'd0, key_in}, 32'h72);
    checkOutput("post_rst_key_ext", {31'd0, key_ext}, 32'd0);
    checkOutput("post_rst_no_err", err_count, exp_err);

    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
